// File: rtl/reg_scoreboard_pkg.sv
// Shared types and sizing for the dual-issue register scoreboard.
package reg_scoreboard_pkg;

  localparam int unsigned QUADWORD       = 128;
  localparam int unsigned REG_COUNT      = 128;
  localparam int unsigned REG_ADDR_WIDTH = $clog2(REG_COUNT);
  // Struct latency field is sized for the widest supported LAT_WIDTH; narrower values zero-extend.
  localparam int unsigned MAX_LAT_WIDTH  = 16;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t                addr_ra;
    reg_addr_t                addr_rb;
    reg_addr_t                addr_rc;
    logic                     use_ra;
    logic                     use_rb;
    logic                     use_rc;
    reg_addr_t                addr_rt;
    logic                     wr_rt;
    logic [MAX_LAT_WIDTH-1:0] lat;
  } instr_t;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue-side bundle between the decode stage (master) and the scoreboard (slave).
interface reg_scoreboard_if
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned LAT_WIDTH = 4
) ();

  logic                 valid_even,   valid_odd;
  reg_addr_t            addr_ra_even, addr_ra_odd;
  reg_addr_t            addr_rb_even, addr_rb_odd;
  reg_addr_t            addr_rc_even, addr_rc_odd;
  logic                 use_ra_even,  use_ra_odd;
  logic                 use_rb_even,  use_rb_odd;
  logic                 use_rc_even,  use_rc_odd;
  reg_addr_t            addr_rt_even, addr_rt_odd;
  logic                 wr_rt_even,   wr_rt_odd;
  logic [LAT_WIDTH-1:0] lat_even,     lat_odd;
  logic                 flush;
  logic                 issue_even,   issue_odd;
  logic [REG_COUNT-1:0] busy_vec;
  logic [31:0]          stall_cycles;

  modport master (
    output valid_even, addr_ra_even, addr_rb_even, addr_rc_even, use_ra_even, use_rb_even,
           use_rc_even, addr_rt_even, wr_rt_even, lat_even,
    output valid_odd, addr_ra_odd, addr_rb_odd, addr_rc_odd, use_ra_odd, use_rb_odd,
           use_rc_odd, addr_rt_odd, wr_rt_odd, lat_odd,
    output flush,
    input  issue_even, issue_odd, busy_vec, stall_cycles
  );

  modport slave (
    input  valid_even, addr_ra_even, addr_rb_even, addr_rc_even, use_ra_even, use_rb_even,
           use_rc_even, addr_rt_even, wr_rt_even, lat_even,
    input  valid_odd, addr_ra_odd, addr_rb_odd, addr_rc_odd, use_ra_odd, use_rb_odd,
           use_rc_odd, addr_rt_odd, wr_rt_odd, lat_odd,
    input  flush,
    output issue_even, issue_odd, busy_vec, stall_cycles
  );

endinterface

// File: rtl/reg_scoreboard_hazard_check.sv
// Per-pipe readiness: used sources and written destination must all be idle.
module hazard_check
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned LAT_WIDTH = 4
) (
  input  instr_t               inst,
  input  logic [REG_COUNT-1:0] busy_vec,
  output logic                 ready,
  output logic [LAT_WIDTH-1:0] load_lat
);

  always_comb begin
    ready = 1'b1;
    if (inst.use_ra && busy_vec[inst.addr_ra]) ready = 1'b0;
    if (inst.use_rb && busy_vec[inst.addr_rb]) ready = 1'b0;
    if (inst.use_rc && busy_vec[inst.addr_rc]) ready = 1'b0;
    if (inst.wr_rt  && busy_vec[inst.addr_rt]) ready = 1'b0;
    // A zero latency would leave the destination looking ready on the very next cycle.
    load_lat = (inst.lat == '0) ? LAT_WIDTH'(1) : LAT_WIDTH'(inst.lat);
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Dual-pipe in-order issue scoreboard with per-register writeback countdowns.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned LAT_WIDTH = 4
) (
  input logic             clk,
  input logic             reset,
  reg_scoreboard_if.slave sb
);

  logic [LAT_WIDTH-1:0] cnt_q [REG_COUNT];
  logic [LAT_WIDTH-1:0] cnt_d [REG_COUNT];
  logic [REG_COUNT-1:0] busy;
  logic [31:0]          stall_q;

  instr_t               inst_even, inst_odd;
  logic                 ready_even, ready_odd;
  logic [LAT_WIDTH-1:0] lat_even, lat_odd;
  logic                 rt_clash, issue_even, issue_odd, stall_inc;

  assign inst_even = '{addr_ra: sb.addr_ra_even, addr_rb: sb.addr_rb_even,
                       addr_rc: sb.addr_rc_even, use_ra: sb.use_ra_even,
                       use_rb: sb.use_rb_even, use_rc: sb.use_rc_even,
                       addr_rt: sb.addr_rt_even, wr_rt: sb.wr_rt_even,
                       lat: MAX_LAT_WIDTH'(sb.lat_even)};
  assign inst_odd  = '{addr_ra: sb.addr_ra_odd, addr_rb: sb.addr_rb_odd,
                       addr_rc: sb.addr_rc_odd, use_ra: sb.use_ra_odd,
                       use_rb: sb.use_rb_odd, use_rc: sb.use_rc_odd,
                       addr_rt: sb.addr_rt_odd, wr_rt: sb.wr_rt_odd,
                       lat: MAX_LAT_WIDTH'(sb.lat_odd)};

  hazard_check #(.LAT_WIDTH(LAT_WIDTH)) u_hazard_even (
    .inst     (inst_even),
    .busy_vec (busy),
    .ready    (ready_even),
    .load_lat (lat_even)
  );

  hazard_check #(.LAT_WIDTH(LAT_WIDTH)) u_hazard_odd (
    .inst     (inst_odd),
    .busy_vec (busy),
    .ready    (ready_odd),
    .load_lat (lat_odd)
  );

  always_comb begin
    for (int unsigned i = 0; i < REG_COUNT; i++) begin
      busy[i] = (cnt_q[i] != '0);
    end
  end

  // Odd must not read or overwrite what the older even instruction writes in the same cycle.
  always_comb begin
    rt_clash = inst_even.wr_rt &&
               ((inst_odd.use_ra && (inst_odd.addr_ra == inst_even.addr_rt)) ||
                (inst_odd.use_rb && (inst_odd.addr_rb == inst_even.addr_rt)) ||
                (inst_odd.use_rc && (inst_odd.addr_rc == inst_even.addr_rt)) ||
                (inst_odd.wr_rt  && (inst_odd.addr_rt == inst_even.addr_rt)));
    issue_even = !reset && !sb.flush && sb.valid_even && ready_even;
    issue_odd  = !reset && !sb.flush && sb.valid_odd && ready_odd &&
                 (issue_even || !sb.valid_even) && !(issue_even && rt_clash);
    stall_inc  = !sb.flush && ((sb.valid_even && !issue_even) || (sb.valid_odd && !issue_odd));
  end

  always_comb begin
    for (int unsigned i = 0; i < REG_COUNT; i++) begin
      cnt_d[i] = busy[i] ? (cnt_q[i] - LAT_WIDTH'(1)) : '0;
    end
    if (issue_even && inst_even.wr_rt) cnt_d[inst_even.addr_rt] = lat_even;
    if (issue_odd && inst_odd.wr_rt)   cnt_d[inst_odd.addr_rt]  = lat_odd;
    if (sb.flush) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        cnt_q[i] <= '0;
      end
      stall_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + 32'd1;
    end
  end

  assign sb.issue_even   = issue_even;
  assign sb.issue_odd    = issue_odd;
  assign sb.busy_vec     = busy;
  assign sb.stall_cycles = stall_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench: directed scenarios plus random traffic against a ready-time model.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  logic   clk = 1'b0;
  bit     rst, ve, vo, fl;
  instr_t e_in, o_in;
  int     checks = 0;
  int     passed = 0;

  // Model: absolute cycle at which each register may next be consumed.
  int unsigned ready_at [REG_COUNT];
  int unsigned cyc;
  int unsigned m_stall;

  always #5 clk = ~clk;

  reg_scoreboard_if #(.LAT_WIDTH(4)) sb_if ();

  assign sb_if.valid_even   = ve;
  assign sb_if.addr_ra_even = e_in.addr_ra;
  assign sb_if.addr_rb_even = e_in.addr_rb;
  assign sb_if.addr_rc_even = e_in.addr_rc;
  assign sb_if.use_ra_even  = e_in.use_ra;
  assign sb_if.use_rb_even  = e_in.use_rb;
  assign sb_if.use_rc_even  = e_in.use_rc;
  assign sb_if.addr_rt_even = e_in.addr_rt;
  assign sb_if.wr_rt_even   = e_in.wr_rt;
  assign sb_if.lat_even     = e_in.lat[3:0];
  assign sb_if.valid_odd    = vo;
  assign sb_if.addr_ra_odd  = o_in.addr_ra;
  assign sb_if.addr_rb_odd  = o_in.addr_rb;
  assign sb_if.addr_rc_odd  = o_in.addr_rc;
  assign sb_if.use_ra_odd   = o_in.use_ra;
  assign sb_if.use_rb_odd   = o_in.use_rb;
  assign sb_if.use_rc_odd   = o_in.use_rc;
  assign sb_if.addr_rt_odd  = o_in.addr_rt;
  assign sb_if.wr_rt_odd    = o_in.wr_rt;
  assign sb_if.lat_odd      = o_in.lat[3:0];
  assign sb_if.flush        = fl;

  reg_scoreboard #(.LAT_WIDTH(4)) dut (
    .clk   (clk),
    .reset (rst),
    .sb    (sb_if)
  );

  function automatic instr_t mk(input int ra, input bit ua, input int rt, input bit wr,
                                input int lat);
    instr_t t = '0;
    t.addr_ra = reg_addr_t'(ra);
    t.use_ra  = ua;
    t.addr_rt = reg_addr_t'(rt);
    t.wr_rt   = wr;
    t.lat     = MAX_LAT_WIDTH'(lat);
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t = '0;
    t.addr_ra = reg_addr_t'($urandom_range(0, 7));
    t.addr_rb = reg_addr_t'($urandom_range(0, 7));
    t.addr_rc = reg_addr_t'($urandom_range(0, 7));
    t.use_ra  = 1'($urandom_range(0, 1));
    t.use_rb  = 1'($urandom_range(0, 1));
    t.use_rc  = 1'($urandom_range(0, 1));
    t.addr_rt = reg_addr_t'($urandom_range(0, 7));
    t.wr_rt   = 1'($urandom_range(0, 1));
    t.lat     = ($urandom_range(0, 7) == 0) ? MAX_LAT_WIDTH'($urandom_range(0, 15))
                                            : MAX_LAT_WIDTH'($urandom_range(0, 3));
    return t;
  endfunction

  function automatic bit rdy(input reg_addr_t r);
    return ready_at[r] <= cyc;
  endfunction

  function automatic bit srcs_ok(input instr_t t);
    return (!t.use_ra || rdy(t.addr_ra)) && (!t.use_rb || rdy(t.addr_rb)) &&
           (!t.use_rc || rdy(t.addr_rc)) && (!t.wr_rt || rdy(t.addr_rt));
  endfunction

  function automatic void model_grants(output bit eg, output bit og);
    bit clash;
    clash = e_in.wr_rt && ((o_in.use_ra && o_in.addr_ra == e_in.addr_rt) ||
                           (o_in.use_rb && o_in.addr_rb == e_in.addr_rt) ||
                           (o_in.use_rc && o_in.addr_rc == e_in.addr_rt) ||
                           (o_in.wr_rt  && o_in.addr_rt == e_in.addr_rt));
    eg = !rst && !fl && ve && srcs_ok(e_in);
    og = !rst && !fl && vo && srcs_ok(o_in) && (!ve || eg) && !(eg && clash);
  endfunction

  function automatic logic [REG_COUNT-1:0] model_busy();
    logic [REG_COUNT-1:0] b;
    for (int r = 0; r < REG_COUNT; r++) b[r] = ready_at[r] > cyc;
    return b;
  endfunction

  // Clock edge: advance the model with the same inputs the DUT samples.
  task automatic advance();
    bit eg, og;
    int unsigned le, lo;
    @(posedge clk);
    model_grants(eg, og);
    le = (e_in.lat[3:0] == 0) ? 1 : e_in.lat[3:0];
    lo = (o_in.lat[3:0] == 0) ? 1 : o_in.lat[3:0];
    if (rst) begin
      for (int r = 0; r < REG_COUNT; r++) ready_at[r] = 0;
      m_stall = 0;
    end else if (fl) begin
      for (int r = 0; r < REG_COUNT; r++) ready_at[r] = 0;
    end else begin
      if (((ve && !eg) || (vo && !og)) && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (eg && e_in.wr_rt) ready_at[e_in.addr_rt] = cyc + le + 1;
      if (og && o_in.wr_rt) ready_at[o_in.addr_rt] = cyc + lo + 1;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1; ve = 0; vo = 0; fl = 0; e_in = '0; o_in = '0;
    advance();
    advance();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (sb_if.busy_vec !== '0) $display("FAIL reset_busy got=%h want 0", sb_if.busy_vec); else passed++;
    checks++; if (sb_if.stall_cycles !== 32'd0) $display("FAIL reset_stall got=%0d want 0", sb_if.stall_cycles); else passed++;
    checks++; if ({sb_if.issue_even, sb_if.issue_odd} !== 2'b00) $display("FAIL reset_idle_grants got=%b want 00", {sb_if.issue_even, sb_if.issue_odd}); else passed++;
    ve = 1; e_in = mk(0, 0, 4, 1, 10);
    advance();
    ve = 0;
    @(negedge clk);
    checks++; if (sb_if.busy_vec[4] !== 1'b1) $display("FAIL reset_preload_busy got=%b want 1", sb_if.busy_vec[4]); else passed++;
    rst = 1; ve = 1; e_in = mk(20, 1, 21, 1, 2);
    @(negedge clk);
    checks++; if (sb_if.issue_even !== 1'b0) $display("FAIL reset_grant_held got=%b want 0", sb_if.issue_even); else passed++;
    advance();
    rst = 0; ve = 0;
    @(negedge clk);
    checks++; if (sb_if.busy_vec !== '0) $display("FAIL reset_midcount_busy got=%h want 0", sb_if.busy_vec); else passed++;
    checks++; if (sb_if.stall_cycles !== 32'd0) $display("FAIL reset_midcount_stall got=%0d want 0", sb_if.stall_cycles); else passed++;
  endtask

  task automatic test_raw();
    do_reset();
    ve = 1; e_in = mk(0, 0, 5, 1, 4);
    @(negedge clk);
    checks++; if (sb_if.issue_even !== 1'b1) $display("FAIL raw_producer got=%b want 1", sb_if.issue_even); else passed++;
    advance();
    e_in = mk(5, 1, 0, 0, 0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++; if (sb_if.issue_even !== 1'(c == 5)) $display("FAIL raw_consumer_c%0d got=%b want %b", c, sb_if.issue_even, c == 5); else passed++;
      advance();
    end
    ve = 0;
    @(negedge clk);
    checks++; if (sb_if.stall_cycles !== 32'd4) $display("FAIL raw_stall got=%0d want 4", sb_if.stall_cycles); else passed++;
  endtask

  task automatic test_same_cycle();
    do_reset();
    ve = 1; e_in = mk(0, 0, 10, 1, 3);
    vo = 1; o_in = mk(10, 1, 0, 0, 0);
    @(negedge clk);
    checks++; if ({sb_if.issue_even, sb_if.issue_odd} !== 2'b10) $display("FAIL same_cycle_grants got=%b want 10", {sb_if.issue_even, sb_if.issue_odd}); else passed++;
    advance();
    ve = 0;
    @(negedge clk);
    checks++; if (sb_if.issue_odd !== 1'b0) $display("FAIL same_cycle_next_odd got=%b want 0", sb_if.issue_odd); else passed++;
    checks++; if (sb_if.busy_vec[10] !== 1'b1) $display("FAIL same_cycle_busy10 got=%b want 1", sb_if.busy_vec[10]); else passed++;
    advance();
    vo = 0;
  endtask

  task automatic test_in_order();
    do_reset();
    ve = 1; e_in = mk(0, 0, 7, 1, 2);
    advance();
    e_in = mk(7, 1, 0, 0, 0);
    vo = 1; o_in = mk(20, 1, 21, 1, 1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++; if ({sb_if.issue_even, sb_if.issue_odd} !== {2{1'(c == 3)}}) $display("FAIL in_order_c%0d got=%b want %b", c, {sb_if.issue_even, sb_if.issue_odd}, {2{1'(c == 3)}}); else passed++;
      advance();
    end
    ve = 0; vo = 0;
  endtask

  task automatic test_flush();
    do_reset();
    ve = 1; e_in = mk(0, 0, 3, 1, 15);
    advance();
    e_in = mk(3, 1, 0, 0, 0);
    advance();
    fl = 1;
    @(negedge clk);
    checks++; if ({sb_if.issue_even, sb_if.issue_odd} !== 2'b00) $display("FAIL flush_grants got=%b want 00", {sb_if.issue_even, sb_if.issue_odd}); else passed++;
    advance();
    fl = 0;
    @(negedge clk);
    checks++; if (sb_if.busy_vec !== '0) $display("FAIL flush_busy got=%h want 0", sb_if.busy_vec); else passed++;
    checks++; if (sb_if.issue_even !== 1'b1) $display("FAIL flush_reader got=%b want 1", sb_if.issue_even); else passed++;
    checks++; if (sb_if.stall_cycles !== 32'd1) $display("FAIL flush_stall got=%0d want 1", sb_if.stall_cycles); else passed++;
    advance();
    ve = 0;
  endtask

  task automatic test_waw();
    do_reset();
    ve = 1; e_in = mk(0, 0, 9, 1, 6);
    vo = 1; o_in = mk(0, 0, 9, 1, 1);
    @(negedge clk);
    checks++; if ({sb_if.issue_even, sb_if.issue_odd} !== 2'b10) $display("FAIL waw_grants got=%b want 10", {sb_if.issue_even, sb_if.issue_odd}); else passed++;
    advance();
    ve = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      checks++; if (sb_if.issue_odd !== 1'(c == 7)) $display("FAIL waw_odd_c%0d got=%b want %b", c, sb_if.issue_odd, c == 7); else passed++;
      advance();
    end
    vo = 0;
  endtask

  task automatic test_lat_zero();
    do_reset();
    ve = 1; e_in = mk(0, 0, 12, 1, 0);
    advance();
    e_in = mk(12, 1, 0, 0, 0);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      checks++; if (sb_if.issue_even !== 1'(c == 2)) $display("FAIL lat_zero_c%0d got=%b want %b", c, sb_if.issue_even, c == 2); else passed++;
      advance();
    end
    ve = 0;
  endtask

  task automatic test_random();
    bit eg, og;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      ve   = 1'($urandom_range(0, 1));
      vo   = 1'($urandom_range(0, 1));
      e_in = rand_instr();
      o_in = rand_instr();
      fl   = ($urandom_range(0, 24) == 0);
      rst  = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      model_grants(eg, og);
      checks++; if (sb_if.issue_even !== eg) $display("FAIL rand_issue_even n=%0d got=%b want %b", n, sb_if.issue_even, eg); else passed++;
      checks++; if (sb_if.issue_odd !== og) $display("FAIL rand_issue_odd n=%0d got=%b want %b", n, sb_if.issue_odd, og); else passed++;
      checks++; if (sb_if.busy_vec !== model_busy()) $display("FAIL rand_busy n=%0d got=%h want %h", n, sb_if.busy_vec, model_busy()); else passed++;
      checks++; if (sb_if.stall_cycles !== m_stall) $display("FAIL rand_stall n=%0d got=%0d want %0d", n, sb_if.stall_cycles, m_stall); else passed++;
      advance();
    end
    rst = 0; ve = 0; vo = 0; fl = 0;
  endtask

  initial begin
    cyc = 0; m_stall = 0;
    for (int r = 0; r < REG_COUNT; r++) ready_at[r] = 0;
    e_in = '0; o_in = '0;
    test_reset();
    test_raw();
    test_same_cycle();
    test_in_order();
    test_flush();
    test_waw();
    test_lat_zero();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter LAT_WIDTH, default 4, meaning width of the producer-latency field and of each per-register countdown.
REQ-002 SHALL have ports, in order: clk, input, 1, single clock, all state on posedge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high.
REQ-004 SHALL have ports valid_even / valid_odd, input, 1 each, an instruction is presented on that pipe; the even instruction is older.
REQ-005 SHALL have ports addr_ra/rb/rc_even and addr_ra/rb/rc_odd, input, REG_ADDR_WIDTH each, source register addresses.
REQ-006 SHALL have ports use_ra/rb/rc_even and use_ra/rb/rc_odd, input, 1 each, the matching source is actually read.
REQ-007 SHALL have ports addr_rt_even / addr_rt_odd, input, REG_ADDR_WIDTH each, destination; wr_rt_even / wr_rt_odd, input, 1 each, destination is written.
REQ-008 SHALL have ports lat_even / lat_odd, input, LAT_WIDTH each, cycles from issue to register-file writeback; legal range 1..2^LAT_WIDTH-1.
REQ-009 SHALL have port flush, input, 1, discards all in-flight tracking.
REQ-010 SHALL have ports issue_even / issue_odd, output, 1 each, grant for that pipe this cycle.
REQ-011 SHALL have port busy_vec, output, REG_COUNT, bit i is set when the countdown of register i is nonzero.
REQ-012 SHALL have port stall_cycles, output, 32, saturating count of cycles with a valid instruction not granted.

Function
REQ-013 SHALL keep one LAT_WIDTH countdown per register, REG_COUNT entries; a register is ready when its countdown is 0.
REQ-014 SHALL compute grants combinationally from current state and inputs, with zero latency.
REQ-015 SHALL assert issue_even when valid_even, no flush, every used even source is ready, and (if wr_rt_even) addr_rt_even is ready (WAW).
REQ-016 SHALL assert issue_odd only when valid_odd, no flush, and either issue_even is high or valid_even is low, giving in-order issue.
REQ-017 For odd, SHALL additionally require every used source and (if wr_rt_odd) the destination to be ready.
REQ-018 When even is granted with wr_rt_even, SHALL additionally block odd if any used odd source equals addr_rt_even, or if wr_rt_odd and addr_rt_odd equals addr_rt_even.
REQ-019 On each posedge, SHALL decrement every nonzero countdown by 1.
REQ-020 A granted writing instruction SHALL load countdown[rt] with its lat; load overrides decrement on the same edge.
REQ-021 lat = 0 on a granted writing instruction SHALL be treated as 1.
REQ-022 Dependent timing: producer granted at cycle t with lat L; a consumer's earliest grant SHALL be cycle t+L+1.
REQ-023 flush SHALL force both grants low that cycle and zero all countdowns at the next edge; flush overrides any load.
REQ-024 stall_cycles SHALL increment when (valid_even and not issue_even) or (valid_odd and not issue_odd), SHALL hold at 0xFFFFFFFF, and SHALL NOT count during flush.
REQ-025 Register 0 SHALL receive no special treatment.

Reset
REQ-026 On reset, SHALL zero all countdowns and stall_cycles, giving busy_vec = 0 at the next edge.
REQ-027 While reset is high, SHALL hold issue_even and issue_odd low.
REQ-028 Reset SHALL override flush, loads and decrements, including reset asserted mid-countdown.

Structure
REQ-029 QUADWORD, REG_ADDR_WIDTH, REG_COUNT, and a packed struct {addr_ra, addr_rb, addr_rc, use bits, addr_rt, wr_rt, lat} SHALL live in the shared package.
REQ-030 Per-pipe source-hazard checking SHALL be one sub-module, hazard_check, instantiated twice.

Verification
REQ-031 Reset then idle: busy_vec = 0, stall_cycles = 0, grants 0.
REQ-032 Even write r5 lat=4 granted at cycle 0; even read r5 from cycle 1: issue_even = 0 in cycles 1-4, 1 in cycle 5; stall_cycles = 4.
REQ-033 Same cycle: even writes r10, odd reads r10: issue_even = 1, issue_odd = 0; the next cycle odd is still blocked by busy r10.
REQ-034 Even blocked on busy r7 while an independent odd is valid: issue_odd = 0; both pipes grant once r7 clears.
REQ-035 r3 loaded lat=15; flush at cycle 2: grants 0 at cycle 2, busy_vec = 0 at cycle 3, a reader of r3 is granted at cycle 3.
REQ-036 Even writes r9 lat=6 and odd writes r9 in the same cycle: only even is granted; the odd WAW waits 6 more cycles.
